// File: rtl/func_sweep.sv
// Sequential truth-table sweeper: walks every input vector of an N_IN-input function,
// samples its output after SETTLE idle cycles, and reports the table and its ones-count.
// Optional expected-table compare is enabled with FUNC_SWEEP_EXPECT_CHECK_EN.
module func_sweep #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [N_IN-1:0]      vec,
    input  logic                 f_in,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic [N_IN:0]        ones_count
`ifdef FUNC_SWEEP_EXPECT_CHECK_EN
    ,
    input  logic [2**N_IN-1:0]   exp_table,
    output logic                 mismatch,
    output logic [N_IN-1:0]      fail_vec
`endif
);

    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
    localparam logic [3:0]      SETTLE_V = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FIN    = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic [N_IN-1:0]      vec_r, vec_s;
    logic [3:0]           cnt_r, cnt_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;
    logic [2**N_IN-1:0]   table_r, table_s;
    logic [N_IN:0]        ones_r, ones_s;
`ifdef FUNC_SWEEP_EXPECT_CHECK_EN
    logic                 mismatch_r, mismatch_s;
    logic [N_IN-1:0]      fail_vec_r, fail_vec_s;
`endif

    // Next-state and next-output computation for the sweep sequencer
    always_comb begin
        state_s    = state_r;
        vec_s      = vec_r;
        cnt_s      = cnt_r;
        busy_s     = busy_r;
        done_s     = done_r;
        table_s    = table_r;
        ones_s     = ones_r;
`ifdef FUNC_SWEEP_EXPECT_CHECK_EN
        mismatch_s = mismatch_r;
        fail_vec_s = fail_vec_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s    = ST_WAIT;
                    vec_s      = '0;
                    cnt_s      = SETTLE_V;
                    table_s    = '0;
                    ones_s     = '0;
                    busy_s     = 1'b1;
`ifdef FUNC_SWEEP_EXPECT_CHECK_EN
                    mismatch_s = 1'b0;
                    fail_vec_s = '0;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r != 4'd0) begin
                    cnt_s = cnt_r - 4'd1;
                end else begin
                    state_s = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                table_s[vec_r] = f_in;
                ones_s         = ones_r + {{N_IN{1'b0}}, f_in};
`ifdef FUNC_SWEEP_EXPECT_CHECK_EN
                // Only the first mismatching vector is latched; the flag stays sticky
                if (f_in != exp_table[vec_r]) begin
                    mismatch_s = 1'b1;
                    if (!mismatch_r) begin
                        fail_vec_s = vec_r;
                    end else begin
                        fail_vec_s = fail_vec_r;
                    end
                end else begin
                    mismatch_s = mismatch_r;
                end
`endif
                if (vec_r == VEC_LAST) begin
                    state_s = ST_FIN;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                    vec_s   = vec_r + {{(N_IN-1){1'b0}}, 1'b1};
                    cnt_s   = SETTLE_V;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
                done_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            vec_r      <= '0;
            cnt_r      <= 4'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            table_r    <= '0;
            ones_r     <= '0;
`ifdef FUNC_SWEEP_EXPECT_CHECK_EN
            mismatch_r <= 1'b0;
            fail_vec_r <= '0;
`endif
        end else begin
            state_r    <= state_s;
            vec_r      <= vec_s;
            cnt_r      <= cnt_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            table_r    <= table_s;
            ones_r     <= ones_s;
`ifdef FUNC_SWEEP_EXPECT_CHECK_EN
            mismatch_r <= mismatch_s;
            fail_vec_r <= fail_vec_s;
`endif
        end
    end

    assign vec        = vec_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign table_out  = table_r;
    assign ones_count = ones_r;
`ifdef FUNC_SWEEP_EXPECT_CHECK_EN
    assign mismatch   = mismatch_r;
    assign fail_vec   = fail_vec_r;
`endif

endmodule

// File: tb/tb_func_sweep.sv
// Directed self-checking bench for func_sweep: a 4-input/SETTLE=1 instance and a
// 3-input/SETTLE=0 instance, each with a bench-side reference function on f_in.
module tb_func_sweep;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, start3;
    int          f_mode;
    logic [3:0]  vec4;
    logic        f4, busy4, done4;
    logic [15:0] table4;
    logic [4:0]  ones4;
    logic [2:0]  vec3;
    logic        f3, busy3, done3;
    logic [7:0]  table3;
    logic [3:0]  ones3;
`ifdef FUNC_SWEEP_EXPECT_CHECK_EN
    logic [15:0] exp4;
    logic [7:0]  exp3;
    logic        mm4, mm3;
    logic [3:0]  fv4;
    logic [2:0]  fv3;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // f = a&b | c&~d, or a constant, selected by f_mode
    assign f4 = (f_mode == 0) ? ((vec4[3] & vec4[2]) | (vec4[1] & ~vec4[0])) :
                (f_mode == 1) ? 1'b0 : 1'b1;
    assign f3 = ^vec3;

    func_sweep #(.N_IN(4), .SETTLE(1)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .vec(vec4), .f_in(f4),
        .busy(busy4), .done(done4), .table_out(table4), .ones_count(ones4)
`ifdef FUNC_SWEEP_EXPECT_CHECK_EN
        , .exp_table(exp4), .mismatch(mm4), .fail_vec(fv4)
`endif
    );

    func_sweep #(.N_IN(3), .SETTLE(0)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .vec(vec3), .f_in(f3),
        .busy(busy3), .done(done3), .table_out(table3), .ones_count(ones3)
`ifdef FUNC_SWEEP_EXPECT_CHECK_EN
        , .exp_table(exp3), .mismatch(mm3), .fail_vec(fv3)
`endif
    );

    task automatic test_reset();
        rst = 1'b1;
        start4 = 1'b0;
        start3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({vec4, busy4, done4, table4, ones4} !== 30'd0)
            $display("FAIL reset4: got vec=%h busy=%b done=%b table=%h ones=%0d want all 0",
                     vec4, busy4, done4, table4, ones4);
        else n_pass++;
        n_checks++;
        if ({vec3, busy3, done3, table3, ones3} !== 17'd0)
            $display("FAIL reset3: got vec=%h busy=%b done=%b table=%h ones=%0d want all 0",
                     vec3, busy3, done3, table3, ones3);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One full 4-input sweep; optionally holds start high for the whole busy/FIN window
    task automatic test_sweep4(input bit hammer, input logic [15:0] exp_tab,
                               input logic [4:0] exp_ones, input string tag);
        int done_cyc, done_cnt, vec_bad, busy_bad;
        done_cyc = -1;
        done_cnt = 0;
        vec_bad  = 0;
        busy_bad = 0;
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        #1;
        if (!hammer) start4 = 1'b0;
        n_checks++;
        if (table4 !== 16'h0000 || ones4 !== 5'd0)
            $display("FAIL %s_clear: got table=%h ones=%0d want 0000/0", tag, table4, ones4);
        else n_pass++;
        for (int cyc = 1; cyc <= 55; cyc++) begin
            if (cyc >= 49) start4 = 1'b0;
            if (done4 === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cyc <= 48) begin
                if (vec4 !== 4'((cyc - 1) / 3)) vec_bad++;
                if (busy4 !== 1'b1) busy_bad++;
            end else begin
                if (vec4 !== 4'hF) vec_bad++;
                if (busy4 !== 1'b0) busy_bad++;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (done_cyc != 49) $display("FAIL %s_done_cycle: got %0d want 49", tag, done_cyc);
        else n_pass++;
        n_checks++;
        if (done_cnt != 1) $display("FAIL %s_done_count: got %0d want 1", tag, done_cnt);
        else n_pass++;
        n_checks++;
        if (vec_bad != 0) $display("FAIL %s_vec_steps: got %0d bad cycles want 0", tag, vec_bad);
        else n_pass++;
        n_checks++;
        if (busy_bad != 0) $display("FAIL %s_busy: got %0d bad cycles want 0", tag, busy_bad);
        else n_pass++;
        n_checks++;
        if (table4 !== exp_tab) $display("FAIL %s_table: got %h want %h", tag, table4, exp_tab);
        else n_pass++;
        n_checks++;
        if (ones4 !== exp_ones) $display("FAIL %s_ones: got %0d want %0d", tag, ones4, exp_ones);
        else n_pass++;
    endtask

    task automatic test_function();
        f_mode = 0;
        test_sweep4(1'b0, 16'hF444, 5'd7, "func");
    endtask

    task automatic test_tied();
        f_mode = 1;
        test_sweep4(1'b0, 16'h0000, 5'd0, "tied0");
        f_mode = 2;
        test_sweep4(1'b0, 16'hFFFF, 5'b10000, "tied1");
        // results hold in IDLE even though f_in now changes
        f_mode = 1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (table4 !== 16'hFFFF || ones4 !== 5'b10000 || vec4 !== 4'hF)
            $display("FAIL hold: got table=%h ones=%0d vec=%h want FFFF/16/F", table4, ones4, vec4);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        f_mode = 0;
        test_sweep4(1'b1, 16'hF444, 5'd7, "hammer");
    endtask

    task automatic test_parity();
        int cyc;
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        cyc = 1;
        while (done3 !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_checks++;
        if (cyc != 17) $display("FAIL parity_done_cycle: got %0d want 17", cyc);
        else n_pass++;
        n_checks++;
        if (table3 !== 8'h96) $display("FAIL parity_table: got %h want 96", table3);
        else n_pass++;
        n_checks++;
        if (ones3 !== 4'd4) $display("FAIL parity_ones: got %0d want 4", ones3);
        else n_pass++;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int guard;
        f_mode = 0;
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        guard = 0;
        while (vec4 !== 4'd7 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (vec4 !== 4'd7) $display("FAIL rstmid_reach: got vec=%h want 7", vec4);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({vec4, busy4, done4, table4, ones4} !== 30'd0)
            $display("FAIL rstmid_clear: got vec=%h busy=%b done=%b table=%h ones=%0d want all 0",
                     vec4, busy4, done4, table4, ones4);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (busy4 !== 1'b0 || vec4 !== 4'd0 || done4 !== 1'b0)
            $display("FAIL rstmid_idle: got busy=%b vec=%h done=%b want 0/0/0", busy4, vec4, done4);
        else n_pass++;
        test_sweep4(1'b0, 16'hF444, 5'd7, "after_rst");
    endtask

`ifdef FUNC_SWEEP_EXPECT_CHECK_EN
    task automatic test_expect();
        f_mode = 0;
        exp4 = 16'hF444;
        test_sweep4(1'b0, 16'hF444, 5'd7, "exp_ok");
        n_checks++;
        if (mm4 !== 1'b0 || fv4 !== 4'd0)
            $display("FAIL exp_ok_flags: got mismatch=%b fail_vec=%0d want 0/0", mm4, fv4);
        else n_pass++;
        exp4 = 16'hF440;
        test_sweep4(1'b0, 16'hF444, 5'd7, "exp_bad");
        n_checks++;
        if (mm4 !== 1'b1 || fv4 !== 4'd2)
            $display("FAIL exp_bad_flags: got mismatch=%b fail_vec=%0d want 1/2", mm4, fv4);
        else n_pass++;
    endtask
`endif

    initial begin
        f_mode = 0;
        rst    = 1'b1;
        start4 = 1'b0;
        start3 = 1'b0;
`ifdef FUNC_SWEEP_EXPECT_CHECK_EN
        exp4 = 16'hF444;
        exp3 = 8'h96;
`endif
        test_reset();
        test_function();
        test_tied();
        test_parity();
        test_back_to_back();
        test_reset_mid();
`ifdef FUNC_SWEEP_EXPECT_CHECK_EN
        test_expect();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
